// File: rtl/ram_arbiter.sv
// ram_arbiter: fixed-priority arbiter for the single synchronous-read program/data
// RAM. Requesters are the boot loader, the data path (LW/SW) and instruction fetch,
// ranked loader > data > fetch. Each grant issues one registered RAM command. Read
// data returns the cycle after ISSUE, together with an rvalid pulse to the owner
// that was recorded at grant time.
// Build option: define ARB_STARVE_GUARD_EN to add the fetch starvation guard. With
// the guard, fetch is promoted above data after it loses STARVE_LIMIT arbitrations
// in a row to the data requester.
module ram_arbiter #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 16,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ld_req,
  input  logic                  dt_req,
  input  logic                  if_req,
  input  logic                  ld_we,
  input  logic                  dt_we,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [ADDR_WIDTH-1:0] dt_addr,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  input  logic [DATA_WIDTH-1:0] ld_wdata,
  input  logic [DATA_WIDTH-1:0] dt_wdata,
  output logic                  ld_gnt,
  output logic                  dt_gnt,
  output logic                  if_gnt,
  output logic                  ld_rvalid,
  output logic                  dt_rvalid,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_LD   = 2'd1,
    OWN_DT   = 2'd2,
    OWN_IF   = 2'd3
  } owner_t;

  state_t                state;
  state_t                state_next;
  owner_t                owner;
  owner_t                winner;
  logic                  arb_cycle;
  logic                  promote_fetch;
  logic                  win_we;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;

  // Read data is not re-registered; the owner's rvalid tells it when to capture.
  assign rdata = ram_rdata;

  // Arbitration runs only while the RAM port is free for a new command (IDLE or WAIT).
  always_comb begin
    arb_cycle = (state == S_IDLE) || (state == S_WAIT);
    winner    = OWN_NONE;
    if (arb_cycle) begin
      if (ld_req) begin
        winner = OWN_LD;
      end else if (promote_fetch && if_req) begin
        winner = OWN_IF;
      end else if (dt_req) begin
        winner = OWN_DT;
      end else if (if_req) begin
        winner = OWN_IF;
      end
    end
  end

  // Select the winning requester's command; fetch can only ever read.
  always_comb begin
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    case (winner)
      OWN_LD: begin
        win_we    = ld_we;
        win_addr  = ld_addr;
        win_wdata = ld_wdata;
      end
      OWN_DT: begin
        win_we    = dt_we;
        win_addr  = dt_addr;
        win_wdata = dt_wdata;
      end
      OWN_IF: begin
        win_we    = 1'b0;
        win_addr  = if_addr;
        win_wdata = '0;
      end
      default: begin
        win_we    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
      end
    endcase
  end

  // State register; reset returns to IDLE so an in-flight read never reports rvalid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state plus the grant/valid pulses, which are decoded from state and owner.
  always_comb begin
    state_next = state;
    ld_gnt     = 1'b0;
    dt_gnt     = 1'b0;
    if_gnt     = 1'b0;
    ld_rvalid  = 1'b0;
    dt_rvalid  = 1'b0;
    if_rvalid  = 1'b0;
    busy       = 1'b0;
    case (state)
      S_IDLE: begin
        if (winner != OWN_NONE) begin
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        busy       = 1'b1;
        state_next = ram_we ? S_IDLE : S_WAIT;
        case (owner)
          OWN_LD:  ld_gnt = 1'b1;
          OWN_DT:  dt_gnt = 1'b1;
          OWN_IF:  if_gnt = 1'b1;
          default: ;
        endcase
      end
      S_WAIT: begin
        busy       = 1'b1;
        state_next = (winner != OWN_NONE) ? S_ISSUE : S_IDLE;
        case (owner)
          OWN_LD:  ld_rvalid = 1'b1;
          OWN_DT:  dt_rvalid = 1'b1;
          OWN_IF:  if_rvalid = 1'b1;
          default: ;
        endcase
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Register the winning command onto the RAM port; enable and strobe last one cycle only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      owner     <= OWN_NONE;
    end else begin
      ram_en <= 1'b0;
      ram_we <= 1'b0;
      if (winner != OWN_NONE) begin
        ram_en    <= 1'b1;
        ram_we    <= win_we;
        ram_addr  <= win_addr;
        ram_wdata <= win_wdata;
        owner     <= winner;
      end
    end
  end

`ifdef ARB_STARVE_GUARD_EN
  localparam int STARVE_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] starve_cnt;

  // Count data wins while fetch is waiting; saturate at the limit, clear once fetch is served or gives up.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (!if_req || if_gnt) begin
      starve_cnt <= '0;
    end else if ((winner == OWN_DT) && (starve_cnt < STARVE_MAX)) begin
      starve_cnt <= starve_cnt + STARVE_W'(1);
    end
  end

  assign promote_fetch = (starve_cnt >= STARVE_MAX);
`else
  // Without the guard the priority is strictly loader > data > fetch and STARVE_LIMIT
  // has no effect; it is folded into a tie-off so the parameter is still referenced.
  logic unused_starve_limit;
  assign unused_starve_limit = (STARVE_LIMIT != 0);
  assign promote_fetch       = 1'b0;
`endif

endmodule
